// File: rtl/ct_loader_if.sv
// rtl/ct_loader_if.sv - byte stream, ct RAM write port and start handshakes of the ct loader
interface ct_loader_if;
   logic       en;
   logic       rdy;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_last;
   logic       in_ready;
   logic [7:0] ct_addr;
   logic [7:0] ct_wrdata;
   logic       ct_wren;
   logic       arc4_rdy;
   logic       arc4_en;
   logic       overflow;
   logic       done;

   // loader side
   modport slave (
      input  en, in_data, in_valid, in_last, arc4_rdy,
      output rdy, in_ready, ct_addr, ct_wrdata, ct_wren, arc4_en, overflow, done
   );

   // system side: stream source, RAM, decryptor
   modport master (
      output en, in_data, in_valid, in_last, arc4_rdy,
      input  rdy, in_ready, ct_addr, ct_wrdata, ct_wren, arc4_en, overflow, done
   );
endinterface

// File: rtl/ct_loader.sv
// rtl/ct_loader.sv - fills the ct RAM with a length-prefixed message, then starts the ARC4 decryptor
module ct_loader #(
   parameter int MAX_LEN = 255
) (
   input logic       clk,
   input logic       rst,
   ct_loader_if.slave bus
);

   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RECV    = 3'd1,
      WRLEN   = 3'd2,
      WAITRDY = 3'd3,
      START   = 3'd4
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] cnt;
   logic       xfer;

   // in_ready is a pure decode of the state register, so a transfer is simply valid while in RECV
   assign xfer = bus.in_valid && (state == RECV);

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state logic; WAITRDY only leaves once the length write has retired (ct_wren low)
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.en) state_nxt = RECV;
         RECV:    if (xfer && bus.in_last) state_nxt = WRLEN;
         WRLEN:   state_nxt = WAITRDY;
         WAITRDY: if (bus.arc4_rdy && !bus.ct_wren) state_nxt = START;
         START:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // state decodes: idle/ready flags and the single-cycle start pulse
   always_comb begin
      bus.rdy      = 1'b0;
      bus.in_ready = 1'b0;
      bus.arc4_en  = 1'b0;
      bus.done     = 1'b0;
      case (state)
         IDLE:    bus.rdy = 1'b1;
         RECV:    bus.in_ready = 1'b1;
         START: begin
            bus.arc4_en = 1'b1;
            bus.done    = 1'b1;
         end
         default: ;
      endcase
   end

   // datapath: byte counter, overflow flag and the registered RAM write port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt           <= 8'd0;
         bus.overflow  <= 1'b0;
         bus.ct_wren   <= 1'b0;
         bus.ct_addr   <= 8'd0;
         bus.ct_wrdata <= 8'd0;
      end else begin
         bus.ct_wren <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.en) begin
                  cnt          <= 8'd0;
                  bus.overflow <= 1'b0;
               end
            end
            RECV: begin
               if (xfer) begin
                  if (cnt < MAX_LEN_B) begin
                     bus.ct_wren   <= 1'b1;
                     bus.ct_addr   <= cnt + 8'd1;
                     bus.ct_wrdata <= bus.in_data;
                     cnt           <= cnt + 8'd1;
                  end else begin
                     // excess bytes are still consumed so the source never stalls
                     bus.overflow <= 1'b1;
                  end
               end
            end
            WRLEN: begin
               // cnt never passes MAX_LEN, so it already is the saturated length
               bus.ct_wren   <= 1'b1;
               bus.ct_addr   <= 8'd0;
               bus.ct_wrdata <= cnt;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ct_loader.sv
// tb/tb_ct_loader.sv - self-checking bench for ct_loader
module tb_ct_loader;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ct_loader_if bus();

   ct_loader #(.MAX_LEN(255)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   localparam int MAXL = 255;

   typedef struct {
      int len;        // bytes streamed
      int gap;        // 0 back-to-back, 1 one idle cycle, 2 random 0..2 idle cycles
      int pat;        // 0 random, 1 index, 2 0x41+index, 3 constant 0x7E
      int rdy_delay;  // cycles arc4_rdy is held low after the length write
      bit en_last;    // hold en high together with the last byte
      int exp_len;
      bit exp_ovf;
      int exp_wren;
   } vec_t;

   vec_t vecs[8];

   int checks = 0;
   int errors = 0;

   logic [7:0] ram [256];
   int   wren_cnt;
   int   aen_cnt;
   int   done_cnt;
   logic prev_arc = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // RAM model and pulse counters, sampled mid-cycle
   always @(negedge clk) begin
      if (bus.ct_wren === 1'b1) begin
         ram[bus.ct_addr] = bus.ct_wrdata;
         wren_cnt++;
      end
      if (bus.arc4_en === 1'b1) begin
         aen_cnt++;
         check("arc4_en_with_arc4_rdy_low", {31'd0, prev_arc}, 32'd1);
      end
      if (bus.done === 1'b1) done_cnt++;
      prev_arc = bus.arc4_rdy;
   end

   task automatic clear_model();
      for (int i = 0; i < 256; i++) ram[i] = 8'bx;
      wren_cnt = 0;
      aen_cnt  = 0;
      done_cnt = 0;
   endtask

   function automatic logic [7:0] pat_byte(input int pat, input int i);
      case (pat)
         1:       return 8'(i);
         2:       return 8'(8'h41 + i);
         3:       return 8'h7E;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   task automatic run_msg(input vec_t v);
      logic [7:0] sent[$];
      int stalls;
      int mism;
      int n_store;
      bit seen;
      bit acc;
      clear_model();
      bus.arc4_rdy = (v.rdy_delay == 0);
      for (int k = 0; k < 50 && !bus.rdy; k++) tick();
      check("rdy_before_en", bus.rdy, 1);
      bus.en = 1'b1;
      tick();
      bus.en = 1'b0;
      check("rdy_after_en", bus.rdy, 0);
      check("in_ready_after_en", bus.in_ready, 1);
      check("overflow_cleared_by_en", bus.overflow, 0);

      stalls = 0;
      for (int i = 0; i < v.len; i++) begin
         int idle;
         idle = (v.gap == 1 && i > 0) ? 1 : (v.gap == 2) ? int'($urandom_range(0, 2)) : 0;
         bus.in_valid = 1'b0;
         repeat (idle) tick();
         bus.in_valid = 1'b1;
         bus.in_data  = pat_byte(v.pat, i);
         bus.in_last  = (i == v.len - 1);
         bus.en       = v.en_last && (i == v.len - 1);
         acc = 1'b0;
         for (int k = 0; k < 10 && !acc; k++) begin
            acc = bus.in_ready;
            if (!acc) stalls++;
            tick();
         end
         sent.push_back(bus.in_data);
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.en       = 1'b0;
      check("in_ready_stalls", stalls, 0);
      check("in_ready_after_last", bus.in_ready, 0);
      check("rdy_after_last", bus.rdy, 0);

      if (v.rdy_delay > 0) begin
         for (int k = 0; k < 10 && ram[0] === 8'bx; k++) tick();
         repeat (v.rdy_delay) tick();
         check("arc4_en_held_off", aen_cnt, 0);
         bus.arc4_rdy = 1'b1;
         tick();
         check("arc4_en_latency", bus.arc4_en, 1);
      end

      seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         if (bus.done === 1'b1) seen = 1'b1;
         else tick();
      end
      check("done_seen", {31'd0, seen}, 1);
      tick();
      check("rdy_after_done", bus.rdy, 1);
      tick();
      tick();

      n_store = (sent.size() > MAXL) ? MAXL : sent.size();
      mism = 0;
      for (int j = 0; j < n_store; j++)
         if (ram[j + 1] !== sent[j]) mism++;
      check("ram_data_mismatches", mism, 0);
      check("ram_len_byte", ram[0], n_store);
      check("ram_len_table", ram[0], v.exp_len);
      check("overflow_flag", bus.overflow, (sent.size() > MAXL) ? 1 : 0);
      check("overflow_table", bus.overflow, v.exp_ovf);
      check("ct_wren_cycles", wren_cnt, v.exp_wren);
      check("arc4_en_pulses", aen_cnt, 1);
      check("done_pulses", done_cnt, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t rv;
      vecs[0] = '{3,   0, 2, 0,  0, 3,   0, 4};
      vecs[1] = '{3,   1, 2, 0,  0, 3,   0, 4};
      vecs[2] = '{300, 0, 1, 0,  0, 255, 1, 256};
      vecs[3] = '{3,   0, 2, 20, 0, 3,   0, 4};
      vecs[4] = '{1,   0, 3, 0,  0, 1,   0, 2};
      vecs[5] = '{255, 2, 0, 3,  1, 255, 0, 256};
      vecs[6] = '{256, 0, 0, 0,  0, 255, 1, 256};
      vecs[7] = '{10,  2, 0, 5,  1, 10,  0, 11};

      bus.en       = 1'b0;
      bus.in_data  = 8'd0;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.arc4_rdy = 1'b1;
      clear_model();
      repeat (3) tick();
      check("reset_rdy",       bus.rdy,       1);
      check("reset_in_ready",  bus.in_ready,  0);
      check("reset_ct_wren",   bus.ct_wren,   0);
      check("reset_ct_addr",   bus.ct_addr,   0);
      check("reset_ct_wrdata", bus.ct_wrdata, 0);
      check("reset_arc4_en",   bus.arc4_en,   0);
      check("reset_done",      bus.done,      0);
      check("reset_overflow",  bus.overflow,  0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) run_msg(vecs[i]);

      // reset in the middle of a 5-byte message, after 2 bytes
      bus.en = 1'b1;
      tick();
      bus.en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(8'hA0 + i);
         bus.in_last  = 1'b0;
         tick();
      end
      bus.in_valid = 1'b0;
      check("pre_reset_ct_wren", bus.ct_wren, 1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_ct_wren",  bus.ct_wren,  0);
      check("async_rst_in_ready", bus.in_ready, 0);
      check("async_rst_arc4_en",  bus.arc4_en,  0);
      check("async_rst_rdy",      bus.rdy,      1);
      tick();
      rst = 1'b0;
      tick();
      rv = '{2, 0, 0, 0, 0, 2, 0, 3};
      run_msg(rv);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ct_loader.md
Name: ct_loader

Overview:
- Writer side of the ARC4 ciphertext memory: fills the 256x8 single-port ct RAM with a length-prefixed message received as a byte stream.
- Byte 0 holds the length; bytes 1..N hold the data. This replaces $readmemh preloading in system-level runs.
- After the memory is written, performs the rdy/en start handshake with the ARC4 decryptor, which then reads the same memory.

Parameters:
- MAX_LEN, 255, maximum stored message length in bytes; must be ≤ 255 so it fits in the 8-bit length byte.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  start request; accepted only when rdy=1
- rdy  output  1  loader idle and able to accept en
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_last  input  1  marks the final byte of the message; qualified by in_valid
- in_ready  output  1  loader accepts a byte this cycle
- ct_addr  output  8  ct RAM address
- ct_wrdata  output  8  ct RAM write data
- ct_wren  output  1  ct RAM write enable
- arc4_rdy  input  1  decryptor idle
- arc4_en  output  1  one-cycle decryptor start pulse
- overflow  output  1  sticky flag: message exceeded MAX_LEN, excess bytes dropped
- done  output  1  one-cycle pulse when arc4_en is issued

Behaviour:
- Reset (async): state IDLE; rdy=1; in_ready=0; ct_wren=0; ct_addr=0; ct_wrdata=0; arc4_en=0; done=0; overflow=0; cnt=0.
- A byte transfer occurs when in_valid=1 and in_ready=1 on the same edge.
- in_ready is a registered state decode: 1 only in RECV.

States:
- IDLE: rdy=1. On en=1: cnt←0, overflow←0, go to RECV. rdy drops in the next cycle. en is ignored in all other states.
- RECV: in_ready=1. On each transfer:
  - If cnt < MAX_LEN: next cycle ct_wren=1, ct_addr=cnt+1, ct_wrdata=in_data; cnt←cnt+1.
  - Otherwise: the byte is consumed but not written, and overflow←1.
  - If in_last=1 on the transfer: go to WRLEN.
  - Transfers may occur back-to-back every cycle.
  - When no transfer occurs, ct_wren=0 the next cycle.
- WRLEN: one cycle. Next cycle ct_wren=1, ct_addr=0, ct_wrdata=cnt (saturated at MAX_LEN). Then go to WAITRDY.
- WAITRDY: ct_wren=0. Wait for arc4_rdy=1 (sampled at least one cycle after the length write completes), then go to START.
- START: arc4_en=1 and done=1 for exactly one cycle, then IDLE.
- Write latency: exactly one cycle from the accepting edge to ct_wren high. ct_wren is never high for more than one cycle per byte.
- The minimum message is one byte (in_last on the first byte), giving length=1.
- overflow holds until the next accepted en or reset.
- arc4_en is never asserted while arc4_rdy=0, and never before the length byte is written.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous); a partially written RAM is not cleaned up.
- en asserted together with the last byte of a prior message has no effect (not in IDLE).

Test Plan:
- Reset, then en pulse, then stream 0x41,0x42,0x43 (last on 0x43) back-to-back with arc4_rdy=1 -> RAM[1..3]=41,42,43; RAM[0]=03; arc4_en and done single pulses one cycle after WAITRDY; rdy=1 afterwards; overflow=0.
- Same message with in_valid gapped (1 idle cycle between bytes) -> identical RAM contents; ct_wren high exactly 4 cycles total.
- Stream 300 bytes 0x00..0x2B wrapping, last on byte 300 -> RAM[1..255] hold the first 255 bytes; RAM[0]=FF; overflow=1; in_ready stays 1 until the last byte is accepted.
- Hold arc4_rdy=0 for 20 cycles after the length write -> arc4_en stays 0; it pulses once, one cycle after arc4_rdy rises.
- Single-byte message 0x7E with in_last -> RAM[1]=7E, RAM[0]=01.
- Assert rst after 2 of 5 bytes -> ct_wren, in_ready, and arc4_en drop asynchronously; rdy=1; a new en followed by 2 bytes yields RAM[0]=02, no overflow.
